// File: rtl/bridge_pkg.sv
// Shared definitions for the H-bridge gate supervisor: FSM state encoding
// and gate index helpers for the request/output bit layout.
package bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRECHARGE = 2'd1,
        ST_RUN       = 2'd2,
        ST_FAULT     = 2'd3
    } state_t;

    // High-side gate bit of leg l.
    function automatic int unsigned HS(input int unsigned l);
        return 2 * l;
    endfunction

    // Low-side gate bit of leg l.
    function automatic int unsigned LS(input int unsigned l);
        return 2 * l + 1;
    endfunction

endpackage

// File: rtl/bridge_gate_supervisor_if.sv
// Control/gate bundle of the bridge gate supervisor. Parameters must match
// those of the bridge_gate_supervisor instance the interface is bound to.
// BRIDGE_FAULT_LOG_EN adds the fault-log outputs.
interface bridge_gate_supervisor_if #(
    parameter int unsigned N_LEGS = 2,
    parameter int unsigned N_SRC  = 3,
    parameter int unsigned DT_W   = 8,
    parameter int unsigned SEL_W  = 2
);
    logic                       i_enable;
    logic [SEL_W-1:0]           i_src_sel;
    logic [N_SRC*2*N_LEGS-1:0]  i_src;
    logic [DT_W-1:0]            i_deadtime;
    logic                       i_fault_clear;
    logic [2*N_LEGS-1:0]        o_gate;
    logic [1:0]                 o_state;
    logic                       o_on;
    logic                       o_fault;
`ifdef BRIDGE_FAULT_LOG_EN
    logic [N_LEGS-1:0]          o_fault_leg;
    logic [7:0]                 o_fault_cnt;

    modport slave (
        input  i_enable, i_src_sel, i_src, i_deadtime, i_fault_clear,
        output o_gate, o_state, o_on, o_fault, o_fault_leg, o_fault_cnt
    );
    modport master (
        output i_enable, i_src_sel, i_src, i_deadtime, i_fault_clear,
        input  o_gate, o_state, o_on, o_fault, o_fault_leg, o_fault_cnt
    );
`else
    modport slave (
        input  i_enable, i_src_sel, i_src, i_deadtime, i_fault_clear,
        output o_gate, o_state, o_on, o_fault
    );
    modport master (
        output i_enable, i_src_sel, i_src, i_deadtime, i_fault_clear,
        input  o_gate, o_state, o_on, o_fault
    );
`endif
endinterface

// File: rtl/dt_gate_channel.sv
// One gate channel: dead-time counter plus registered gate drive.
// The output rises once the request has been high for dt_i cycles and the
// leg partner's registered output is low; it falls as soon as the request
// drops. Outside RUN the flop simply loads hold_i.
module dt_gate_channel #(
    parameter int unsigned DT_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            partner_i,
    input  logic [DT_W-1:0] dt_i,
    input  logic            run_i,
    input  logic            hold_i,
    output logic            out_o
);

    logic [DT_W-1:0] cnt_q, cnt_d;
    logic            out_q, out_d;

    // Next-state: saturating high-time count and interlocked rise.
    always_comb begin
        cnt_d = cnt_q;
        out_d = out_q;
        if (!run_i) begin
            cnt_d = '0;
            out_d = hold_i;
        end else if (!req_i) begin
            cnt_d = '0;
            out_d = 1'b0;
        end else begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + DT_W'(1);
            end
            out_d = out_q | ((cnt_q >= dt_i) & ~partner_i);
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/bridge_gate_supervisor.sv
// H-bridge gate supervisor: source select, bootstrap precharge/run/fault
// FSM, per-gate dead time with leg interlock, sticky shoot-through fault.
// Optional BRIDGE_FAULT_LOG_EN: leg mask and saturating count of faults.
module bridge_gate_supervisor
    import bridge_pkg::*;
#(
    parameter int unsigned N_LEGS        = 2,
    parameter int unsigned N_SRC         = 3,
    parameter int unsigned DT_W          = 8,
    parameter int unsigned PRECHARGE_CYC = 1000,
    parameter int unsigned SEL_W         = 2
) (
    input  logic                     i_clock,
    input  logic                     i_RESET,
    bridge_gate_supervisor_if.slave  bus
);

    localparam int unsigned G    = 2 * N_LEGS;
    localparam int unsigned PC_W = (PRECHARGE_CYC > 1) ? $clog2(PRECHARGE_CYC) : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRECHARGE_CYC - 1);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [DT_W-1:0]   dt_q;
    logic              fault_q;
    logic              on_q;

    logic [G-1:0]      req;
    logic [G-1:0]      gate;
    logic [N_LEGS-1:0] shoot_leg;
    logic              shoot;
    logic              pc_done;
    logic              run_go;
    logic              pre_next;

    // Source mux; out-of-range selects yield an all-zero request.
    always_comb begin
        req = '0;
        for (int unsigned s = 0; s < N_SRC; s++) begin
            if (bus.i_src_sel == SEL_W'(s)) begin
                req = bus.i_src[s*G +: G];
            end
        end
    end

    // Per-leg shoot-through detect on the selected request.
    always_comb begin
        shoot_leg = '0;
        for (int unsigned l = 0; l < N_LEGS; l++) begin
            shoot_leg[l] = req[HS(l)] & req[LS(l)];
        end
    end

    assign shoot    = (state_q == ST_RUN) && (|shoot_leg);
    assign pc_done  = (pc_q == PC_LAST);
    assign run_go   = (state_q == ST_RUN) && bus.i_enable && !shoot;
    assign pre_next = bus.i_enable &&
                      ((state_q == ST_IDLE) || ((state_q == ST_PRECHARGE) && !pc_done));

    // The precharge pattern is loaded into the channel flops through hold_i,
    // so every gate drive comes straight from one flop in all states.
    for (genvar g = 0; g < G; g++) begin : g_ch
        localparam int unsigned PARTNER = (g % 2 == 1) ? g - 1 : g + 1;
        localparam bit          IS_LS   = (g % 2 == 1);
        dt_gate_channel #(.DT_W(DT_W)) u_ch (
            .clk_i     (i_clock),
            .rst_i     (i_RESET),
            .req_i     (req[g]),
            .partner_i (gate[PARTNER]),
            .dt_i      (dt_q),
            .run_i     (run_go),
            .hold_i    (IS_LS ? pre_next : 1'b0),
            .out_o     (gate[g])
        );
    end

    // Supervisor FSM with registered status outputs.
    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            dt_q    <= '0;
            fault_q <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.i_enable) begin
                        dt_q    <= bus.i_deadtime;
                        pc_q    <= '0;
                        state_q <= ST_PRECHARGE;
                    end
                end
                ST_PRECHARGE: begin
                    if (!bus.i_enable) begin
                        state_q <= ST_IDLE;
                    end else if (pc_done) begin
                        state_q <= ST_RUN;
                        on_q    <= 1'b1;
                    end else begin
                        pc_q <= pc_q + PC_W'(1);
                    end
                end
                ST_RUN: begin
                    if (shoot) begin
                        state_q <= ST_FAULT;
                        fault_q <= 1'b1;
                        on_q    <= 1'b0;
                    end else if (!bus.i_enable) begin
                        state_q <= ST_IDLE;
                        on_q    <= 1'b0;
                    end
                end
                ST_FAULT: begin
                    if (bus.i_fault_clear && !bus.i_enable) begin
                        state_q <= ST_IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    on_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_gate  = gate;
    assign bus.o_state = state_q;
    assign bus.o_on    = on_q;
    assign bus.o_fault = fault_q;

`ifdef BRIDGE_FAULT_LOG_EN
    logic [N_LEGS-1:0] fleg_q;
    logic [7:0]        fcnt_q;

    // Fault log: offending legs of the last entry, saturating entry count.
    always_ff @(posedge i_clock or posedge i_RESET) begin
        if (i_RESET) begin
            fleg_q <= '0;
            fcnt_q <= '0;
        end else if (shoot) begin
            fleg_q <= shoot_leg;
            if (fcnt_q != '1) begin
                fcnt_q <= fcnt_q + 8'd1;
            end
        end else if ((state_q == ST_FAULT) && bus.i_fault_clear && !bus.i_enable) begin
            fleg_q <= '0;
        end
    end

    assign bus.o_fault_leg = fleg_q;
    assign bus.o_fault_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_bridge_gate_supervisor.sv
// Bench for bridge_gate_supervisor: directed sequences, a vector table and
// randomized runs, all compared against a cycle-stamp reference model.
module tb_bridge_gate_supervisor;

    localparam int NL  = 2;
    localparam int NS  = 3;
    localparam int DTW = 8;
    localparam int PC  = 1000;
    localparam int SW  = 2;
    localparam int G   = 2 * NL;

    localparam int M_IDLE  = 0;
    localparam int M_PRE   = 1;
    localparam int M_RUN   = 2;
    localparam int M_FAULT = 3;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    // Reference model state
    int          m_state;
    int          m_pc;
    int          m_dt;
    bit          m_fault;
    logic [G-1:0] m_gate;
    longint      m_since [G];
    longint      m_edge;
`ifdef BRIDGE_FAULT_LOG_EN
    logic [NL-1:0] m_fleg;
    int            m_fcnt;
`endif

    typedef struct {
        bit          en;
        int          sel;
        logic [3:0]  src0;
        bit          clr;
        logic [3:0]  gate;
        int          state;
        bit          fault;
    } vec_t;

    vec_t tbl [16];

    bridge_gate_supervisor_if #(.N_LEGS(NL), .N_SRC(NS), .DT_W(DTW), .SEL_W(SW)) bus ();

    bridge_gate_supervisor #(
        .N_LEGS(NL), .N_SRC(NS), .DT_W(DTW), .PRECHARGE_CYC(PC), .SEL_W(SW)
    ) dut (
        .i_clock (clk),
        .i_RESET (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = 0;
        m_dt    = 0;
        m_fault = 1'b0;
        m_gate  = '0;
        for (int g = 0; g < G; g++) m_since[g] = -1;
`ifdef BRIDGE_FAULT_LOG_EN
        m_fleg = '0;
        m_fcnt = 0;
`endif
    endtask

    function automatic logic [G-1:0] pre_pattern();
        logic [G-1:0] p;
        p = '0;
        for (int l = 0; l < NL; l++) p[2*l+1] = 1'b1;
        return p;
    endfunction

    // One clock edge of the specified behaviour, with inputs as sampled.
    task automatic model_edge(input bit en, input int sel, input logic [NS*G-1:0] src,
                              input int dtin, input bit clr);
        logic [G-1:0]  req;
        logic [G-1:0]  ng;
        logic [NL-1:0] smask;
        m_edge++;
        req = '0;
        if (sel < NS) req = src[sel*G +: G];
        smask = '0;
        for (int l = 0; l < NL; l++) smask[l] = req[2*l] & req[2*l+1];
        case (m_state)
            M_IDLE: begin
                m_gate = '0;
                if (en) begin
                    m_dt = dtin; m_pc = 0; m_state = M_PRE; m_gate = pre_pattern();
                end
            end
            M_PRE: begin
                if (!en) begin
                    m_state = M_IDLE; m_gate = '0;
                end else begin
                    m_pc++;
                    if (m_pc == PC) begin
                        m_state = M_RUN; m_gate = '0;
                        for (int g = 0; g < G; g++) m_since[g] = -1;
                    end else begin
                        m_gate = pre_pattern();
                    end
                end
            end
            M_RUN: begin
                if (smask != '0) begin
                    m_state = M_FAULT; m_fault = 1'b1; m_gate = '0;
                    for (int g = 0; g < G; g++) m_since[g] = -1;
`ifdef BRIDGE_FAULT_LOG_EN
                    m_fleg = smask;
                    if (m_fcnt < 255) m_fcnt++;
`endif
                end else if (!en) begin
                    m_state = M_IDLE; m_gate = '0;
                    for (int g = 0; g < G; g++) m_since[g] = -1;
                end else begin
                    ng = '0;
                    for (int g = 0; g < G; g++) begin
                        if (!req[g]) begin
                            m_since[g] = -1;
                        end else begin
                            if (m_since[g] < 0) m_since[g] = m_edge;
                            if (m_gate[g] || (((m_edge - m_since[g]) >= m_dt) && !m_gate[g ^ 1]))
                                ng[g] = 1'b1;
                        end
                    end
                    m_gate = ng;
                end
            end
            default: begin
                m_gate = '0;
                if (clr && !en) begin
                    m_state = M_IDLE; m_fault = 1'b0;
`ifdef BRIDGE_FAULT_LOG_EN
                    m_fleg = '0;
`endif
                end
            end
        endcase
    endtask

    // Advance one clock, update the model, compare every output.
    task automatic tick();
        bit              en;
        bit              clr;
        int              sel;
        int              dtin;
        logic [NS*G-1:0] src;
        en   = bus.i_enable;
        clr  = bus.i_fault_clear;
        sel  = int'(bus.i_src_sel);
        dtin = int'(bus.i_deadtime);
        src  = bus.i_src;
        @(posedge clk);
        model_edge(en, sel, src, dtin, clr);
        #1;
        chk("m_gate", 32'(bus.o_gate), 32'(m_gate));
        chk("m_state", 32'(bus.o_state), 32'(m_state));
        chk("m_on", 32'(bus.o_on), (m_state == M_RUN) ? 32'd1 : 32'd0);
        chk("m_fault", 32'(bus.o_fault), 32'(m_fault));
        for (int l = 0; l < NL; l++)
            chk("interlock", 32'(bus.o_gate[2*l] & bus.o_gate[2*l+1]), 32'd0);
`ifdef BRIDGE_FAULT_LOG_EN
        chk("m_fault_leg", 32'(bus.o_fault_leg), 32'(m_fleg));
        chk("m_fault_cnt", 32'(bus.o_fault_cnt), 32'(m_fcnt));
`endif
    endtask

    task automatic wait_run();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (bus.o_state == 2'd2) break;
        end
        chk("wait_run", 32'(bus.o_state), 32'd2);
    endtask

    initial begin
        int n_pre;
        int t_fall;
        int t_rise;
        int t_rise2;
        tests = 0;
        fails = 0;
        m_edge = 0;
        bus.i_enable      = 1'b0;
        bus.i_src_sel     = '0;
        bus.i_src         = '0;
        bus.i_deadtime    = '0;
        bus.i_fault_clear = 1'b0;

        // Vector table, dt = 2, applied from a fresh RUN entry on source 0.
        tbl[0]  = '{1'b1, 0, 4'b0001, 1'b0, 4'b0000, 2, 1'b0};
        tbl[1]  = '{1'b1, 0, 4'b0001, 1'b0, 4'b0000, 2, 1'b0};
        tbl[2]  = '{1'b1, 0, 4'b0001, 1'b0, 4'b0001, 2, 1'b0};
        tbl[3]  = '{1'b1, 0, 4'b0010, 1'b0, 4'b0000, 2, 1'b0};
        tbl[4]  = '{1'b1, 0, 4'b0010, 1'b0, 4'b0000, 2, 1'b0};
        tbl[5]  = '{1'b1, 0, 4'b0010, 1'b0, 4'b0010, 2, 1'b0};
        tbl[6]  = '{1'b1, 0, 4'b0110, 1'b0, 4'b0010, 2, 1'b0};
        tbl[7]  = '{1'b1, 0, 4'b0110, 1'b0, 4'b0010, 2, 1'b0};
        tbl[8]  = '{1'b1, 0, 4'b0110, 1'b0, 4'b0110, 2, 1'b0};
        tbl[9]  = '{1'b1, 3, 4'b0110, 1'b0, 4'b0000, 2, 1'b0};
        tbl[10] = '{1'b1, 0, 4'b0110, 1'b0, 4'b0000, 2, 1'b0};
        tbl[11] = '{1'b1, 0, 4'b1010, 1'b0, 4'b0000, 2, 1'b0};
        tbl[12] = '{1'b1, 0, 4'b1010, 1'b0, 4'b0010, 2, 1'b0};
        tbl[13] = '{1'b1, 0, 4'b1010, 1'b0, 4'b1010, 2, 1'b0};
        tbl[14] = '{1'b1, 0, 4'b0011, 1'b0, 4'b0000, 3, 1'b1};
        tbl[15] = '{1'b0, 0, 4'b0011, 1'b1, 4'b0000, 0, 1'b0};

        // Reset state
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gate", 32'(bus.o_gate), 32'd0);
        chk("rst_state", 32'(bus.o_state), 32'd0);
        chk("rst_on", 32'(bus.o_on), 32'd0);
        chk("rst_fault", 32'(bus.o_fault), 32'd0);
        rst = 1'b0;
        tick();

        // Precharge: low sides on for exactly PC cycles, then RUN
        bus.i_deadtime = 8'd10;
        bus.i_src[3:0] = 4'b1010;
        bus.i_enable   = 1'b1;
        tick();
        chk("pre_entry_gate", 32'(bus.o_gate), 32'b1010);
        chk("pre_entry_state", 32'(bus.o_state), 32'd1);
        n_pre = 1;
        for (int i = 0; i < 2000 && bus.o_state == 2'd1; i++) begin
            tick();
            if (bus.o_state == 2'd1 && bus.o_gate == 4'b1010) n_pre++;
        end
        chk("pre_len", 32'(n_pre), 32'(PC));
        chk("run_state", 32'(bus.o_state), 32'd2);
        chk("run_on", 32'(bus.o_on), 32'd1);
        repeat (11) tick();
        chk("run_ls_on", 32'(bus.o_gate), 32'b1010);

        // Dead time on leg0 LS -> HS, dt = 10
        bus.i_src[3:0] = 4'b1001;
        t_fall = -1; t_rise = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (t_fall < 0 && !bus.o_gate[1]) t_fall = i;
            if (t_rise < 0 && bus.o_gate[0]) t_rise = i;
        end
        chk("dt_ls_fall", 32'(t_fall), 32'd1);
        chk("dt_hs_rise", 32'(t_rise), 32'd11);

        // Shoot-through on leg1 for one cycle
        bus.i_src[3:0] = 4'b1101;
        tick();
        bus.i_src[3:0] = 4'b1001;
        chk("st_gate", 32'(bus.o_gate), 32'd0);
        chk("st_fault", 32'(bus.o_fault), 32'd1);
        chk("st_state", 32'(bus.o_state), 32'd3);

        // Fault clear ignored while enabled, honoured once disabled
        bus.i_fault_clear = 1'b1;
        tick();
        bus.i_fault_clear = 1'b0;
        chk("fc_hold_state", 32'(bus.o_state), 32'd3);
        chk("fc_hold_fault", 32'(bus.o_fault), 32'd1);
        bus.i_enable = 1'b0;
        tick();
        chk("fc_en0_state", 32'(bus.o_state), 32'd3);
        bus.i_fault_clear = 1'b1;
        tick();
        bus.i_fault_clear = 1'b0;
        chk("fc_state", 32'(bus.o_state), 32'd0);
        chk("fc_fault", 32'(bus.o_fault), 32'd0);

        // Enable drop mid-RUN, dt = 3
        bus.i_deadtime = 8'd3;
        bus.i_enable   = 1'b1;
        wait_run();
        repeat (6) tick();
        chk("ed_before", 32'(bus.o_gate), 32'b1001);
        bus.i_enable = 1'b0;
        tick();
        chk("ed_gate", 32'(bus.o_gate), 32'd0);
        chk("ed_state", 32'(bus.o_state), 32'd0);

        // Source change 0 -> 2 with complementary requests
        bus.i_src[11:8] = 4'b0110;
        bus.i_enable    = 1'b1;
        wait_run();
        repeat (6) tick();
        chk("sc_before", 32'(bus.o_gate), 32'b1001);
        bus.i_src_sel = 2'd2;
        t_fall = -1; t_rise = -1; t_rise2 = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (t_fall < 0 && !bus.o_gate[0]) t_fall = i;
            if (t_rise < 0 && bus.o_gate[1]) t_rise = i;
            if (t_rise2 < 0 && bus.o_gate[2]) t_rise2 = i;
        end
        chk("sc_hs_fall", 32'(t_fall), 32'd1);
        chk("sc_ls_rise", 32'(t_rise), 32'd4);
        chk("sc_leg1_rise", 32'(t_rise2), 32'd4);
        chk("sc_after", 32'(bus.o_gate), 32'b0110);

        // Invalid select gives all-zero requests, no fault
        bus.i_src_sel = 2'd3;
        repeat (5) tick();
        chk("inv_gate", 32'(bus.o_gate), 32'd0);
        chk("inv_state", 32'(bus.o_state), 32'd2);
        chk("inv_fault", 32'(bus.o_fault), 32'd0);
        bus.i_src_sel = 2'd0;

        // Vector table
        bus.i_enable = 1'b0;
        tick();
        bus.i_deadtime = 8'd2;
        bus.i_src      = '0;
        bus.i_enable   = 1'b1;
        wait_run();
        for (int i = 0; i < 16; i++) begin
            bus.i_enable      = tbl[i].en;
            bus.i_src_sel     = SW'(tbl[i].sel);
            bus.i_src[3:0]    = tbl[i].src0;
            bus.i_fault_clear = tbl[i].clr;
            tick();
            chk("tbl_gate", 32'(bus.o_gate), 32'(tbl[i].gate));
            chk("tbl_state", 32'(bus.o_state), 32'(tbl[i].state));
            chk("tbl_fault", 32'(bus.o_fault), 32'(tbl[i].fault));
        end
        bus.i_fault_clear = 1'b0;
        bus.i_src         = '0;

        // Asynchronous reset in the middle of precharge
        bus.i_enable = 1'b1;
        repeat (6) tick();
        chk("rr_pre", 32'(bus.o_state), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rr_gate", 32'(bus.o_gate), 32'd0);
        chk("rr_state", 32'(bus.o_state), 32'd0);
        chk("rr_on", 32'(bus.o_on), 32'd0);
        chk("rr_fault", 32'(bus.o_fault), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized runs
        for (int ep = 0; ep < 6; ep++) begin
            bus.i_enable      = 1'b0;
            bus.i_fault_clear = 1'b1;
            tick();
            bus.i_fault_clear = 1'b0;
            tick();
            bus.i_deadtime = DTW'($urandom_range(0, 12));
            bus.i_src_sel  = '0;
            bus.i_enable   = 1'b1;
            wait_run();
            for (int c = 0; c < 300; c++) begin
                if ($urandom_range(0, 7) == 0) begin
                    int s;
                    s = $urandom_range(0, NS - 1);
                    for (int l = 0; l < NL; l++) begin
                        int r;
                        logic [1:0] pat;
                        r = $urandom_range(0, 31);
                        pat = (r == 0) ? 2'b11 : (r < 11) ? 2'b00 : (r < 21) ? 2'b01 : 2'b10;
                        bus.i_src[s*G + 2*l +: 2] = pat;
                    end
                end
                if ($urandom_range(0, 39) == 0) bus.i_src_sel = SW'($urandom_range(0, 3));
                bus.i_deadtime    = DTW'($urandom);
                bus.i_fault_clear = ($urandom_range(0, 49) == 0);
                if ($urandom_range(0, 149) == 0) bus.i_enable = 1'b0;
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bridge_gate_supervisor.md
Name: bridge_gate_supervisor

Overview:
Parametrised H-bridge gate supervisor sitting between the control-law blocks (theta, phi, theta+phi) and the MOSFET pins. Selects one of N_SRC gate-request sources and runs a bootstrap precharge/run/fault state machine. Enforces a runtime-programmable per-gate dead time and a complementary interlock per leg. Latches shoot-through faults. Generalises the fixed dead-time, fixed startup counter and combinational ALERT logic to N legs and N sources, with a sticky fault.

Parameters:
N_LEGS, 2, number of half-bridge legs (2 gates each)
N_SRC, 3, number of selectable gate-request sources
DT_W, 8, width of dead-time value in clock cycles
PRECHARGE_CYC, 1000, bootstrap precharge length in cycles (10 us at 100 MHz)
SEL_W, 2, width of source select (>= clog2(N_SRC))

Ports:
i_clock  in  1  system clock (100 MHz)
i_RESET  in  1  asynchronous, active-high reset
i_enable  in  1  converter enable (debounced switch)
i_src_sel  in  SEL_W  source select; values >= N_SRC select all-zero requests
i_src  in  N_SRC*2*N_LEGS  request vectors; source s at [s*2*N_LEGS +: 2*N_LEGS]; bit 2l = high side leg l, bit 2l+1 = low side leg l
i_deadtime  in  DT_W  dead time in cycles
i_fault_clear  in  1  fault acknowledge
o_gate  out  2*N_LEGS  registered gate drives, same bit order as a request vector
o_state  out  2  FSM state
o_on  out  1  high in RUN
o_fault  out  1  sticky shoot-through fault

Behaviour:
- Reset: o_gate=0, o_state=IDLE, o_on=0, o_fault=0. Precharge counter=0. Dead-time latch=0. All channel counters=0.
- States: IDLE(0), PRECHARGE(1), RUN(2), FAULT(3).
- IDLE: all gates 0. If i_enable=1, latch i_deadtime into dt_q, clear the counter and go to PRECHARGE.
- PRECHARGE: high sides 0, low sides 1 (from the next cycle's registered output). Requests are ignored, so no fault can be raised. Counter increments each cycle. After PRECHARGE_CYC cycles in state, go to RUN.
- RUN: gate requests come from the selected source.
  - A gate output rises only after its request has been continuously high for dt_q cycles AND its leg partner's registered output is 0.
  - Request rise at edge k gives output rise at edge k+dt_q+1. dt_q=0 gives 1-cycle latency.
  - Request fall gives output fall at the next edge; no delay. The channel counter clears on any low request.
  - A partner-held gate's counter keeps counting. The gate rises the cycle after the partner output falls, provided its count >= dt_q.
- Shoot-through: in RUN, if both request bits of any leg are 1 in the same cycle, the FSM goes to FAULT. All o_gate are 0 on that same registered edge, and o_fault goes to 1.
- FAULT: all gates 0, o_fault held.
  - Leaves only to IDLE, and only when i_fault_clear=1 and i_enable=0.
  - i_fault_clear while i_enable=1 is ignored.
- i_enable=0 in PRECHARGE or RUN: go to IDLE with all gates 0 next edge. No dead time is applied on turn-off. i_enable=0 in FAULT keeps FAULT.
- Simultaneous events: a shoot-through request has priority over i_enable falling in RUN.
- i_deadtime is used only when latched; changes during RUN are ignored.
- i_src_sel may change mid-RUN; the dead-time logic handles the transition and no extra blanking is inserted.
- Interlock invariant: o_gate[2l] & o_gate[2l+1] is never 1, in any state.
- Async reset mid-operation clears all outputs immediately (combinationally via flops), not on the next clock edge.
- o_on is 1 exactly when o_state==RUN.

Optional Feature:
BRIDGE_FAULT_LOG_EN
- Defined: adds output o_fault_leg [N_LEGS], which latches the mask of legs that requested shoot-through on the fault-entry cycle. It also adds o_fault_cnt [7:0], a saturating count (at 255) of fault entries. The count is cleared only by i_RESET; the leg mask is cleared on FAULT->IDLE.
- Undefined: neither port exists, and the fault behaviour is otherwise identical.

Decomposition:
- Package bridge_pkg: state encodings ST_IDLE/ST_PRECHARGE/ST_RUN/ST_FAULT; gate index helpers (HS(l)=2l, LS(l)=2l+1).
- Sub-module dt_gate_channel, instantiated 2*N_LEGS times.
  - Inputs: request, partner output, dt_q, run.
  - Holds the DT_W-bit saturating counter and the registered output.
  - The top holds the FSM, source mux, precharge counter and fault logic.

Test Plan:
- Precharge: N_LEGS=2, PRECHARGE_CYC=1000, i_deadtime=10, assert i_enable -> o_gate=4'b1010 for 1000 cycles, then o_state=RUN and o_on=1.
- Dead time: in RUN, source requests leg0 switch from LS to HS at edge k -> LS output falls at k+1, HS output rises at k+11; never both high.
- Shoot-through: request 2'b11 on leg1 for one cycle -> o_gate=0 next edge, o_fault=1, o_state=FAULT.
- Fault clear: pulse i_fault_clear with i_enable=1 -> remains FAULT. Drop i_enable, then pulse clear -> IDLE, o_fault=0.
- Enable drop and source change: drop i_enable mid-RUN -> o_gate=0 next edge. Separately, switch i_src_sel 0->2 with complementary requests -> dead-time gap of dt_q cycles observed.
- Reset and invalid select: i_RESET mid-PRECHARGE -> all outputs 0 immediately. i_src_sel=3 with N_SRC=3 -> all gates 0 in RUN, no fault.
